// File: rtl/lbist_controller.sv
// Logic-BIST run sequencer: feeds each seed to the LFSR and the hash count to the MISR,
// then checks the returned MISR signature against its golden value.
module lbist_controller #(
  parameter int unsigned SEED_BITS           = 32,
  parameter int unsigned SIGNATURE_BITS      = 32,
  parameter int unsigned NUM_SEEDS           = 4,
  parameter int unsigned MAX_OUTPUTS_TO_HASH = 32,
  parameter int unsigned LBIST_MSG_BITS      = $clog2(MAX_OUTPUTS_TO_HASH),
  parameter logic [NUM_SEEDS*SEED_BITS-1:0]      SEEDS      = '0,
  parameter logic [NUM_SEEDS*SIGNATURE_BITS-1:0] SIGNATURES = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_val,
  output logic                      start_rdy,
  output logic                      lfsr_req_val,
  output logic [SEED_BITS-1:0]      lfsr_req_msg,
  input  logic                      lfsr_req_rdy,
  output logic                      misr_req_val,
  output logic [LBIST_MSG_BITS:0]   misr_req_msg,
  input  logic                      misr_req_rdy,
  input  logic                      misr_resp_val,
  input  logic [SIGNATURE_BITS-1:0] misr_resp_msg,
  output logic                      misr_resp_rdy,
  output logic                      done_val,
  output logic [NUM_SEEDS-1:0]      done_msg,
  input  logic                      done_rdy
);

  localparam int unsigned IDX_BITS = (NUM_SEEDS > 1) ? $clog2(NUM_SEEDS) : 1;
  localparam int unsigned MSG_BITS = LBIST_MSG_BITS + 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_SEEDS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_SIG = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [IDX_BITS-1:0]  idx;
  logic [NUM_SEEDS-1:0] result;
  logic                 lfsr_sent;
  logic                 misr_sent;

  logic start_fire;
  logic lfsr_fire;
  logic misr_fire;
  logic resp_fire;
  logic done_fire;
  logic send_done;
  logic sig_match;

  assign start_fire = start_val && start_rdy;
  assign lfsr_fire  = lfsr_req_val && lfsr_req_rdy;
  assign misr_fire  = misr_req_val && misr_req_rdy;
  assign resp_fire  = misr_resp_val && misr_resp_rdy;
  assign done_fire  = done_val && done_rdy;

  // Seed is finished once both requests have been accepted, possibly in the same cycle.
  assign send_done = (lfsr_sent || lfsr_fire) && (misr_sent || misr_fire);
  assign sig_match = (misr_resp_msg == SIGNATURES[32'(idx)*SIGNATURE_BITS +: SIGNATURE_BITS]);

  assign lfsr_req_msg = SEEDS[32'(idx)*SEED_BITS +: SEED_BITS];
  assign misr_req_msg = MSG_BITS'(MAX_OUTPUTS_TO_HASH);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start_fire) state_next = SEND;
      SEND:     if (send_done)  state_next = WAIT_SIG;
      WAIT_SIG: if (resp_fire)  state_next = (idx == LAST_IDX) ? DONE : SEND;
      DONE:     if (done_fire)  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Moore handshake outputs
  always_comb begin
    start_rdy     = 1'b0;
    lfsr_req_val  = 1'b0;
    misr_req_val  = 1'b0;
    misr_resp_rdy = 1'b0;
    done_val      = 1'b0;
    done_msg      = '0;
    case (state)
      IDLE:     start_rdy     = 1'b1;
      SEND: begin
        lfsr_req_val = !lfsr_sent;
        misr_req_val = !misr_sent;
      end
      WAIT_SIG: misr_resp_rdy = 1'b1;
      DONE: begin
        done_val = 1'b1;
        done_msg = result;
      end
      default: ;
    endcase
  end

  // Seed index, per-seed pass bits and request-sent flags
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      result    <= '0;
      lfsr_sent <= 1'b0;
      misr_sent <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_fire) begin
            idx       <= '0;
            result    <= '0;
            lfsr_sent <= 1'b0;
            misr_sent <= 1'b0;
          end
        end
        SEND: begin
          if (send_done) begin
            lfsr_sent <= 1'b0;
            misr_sent <= 1'b0;
          end else begin
            if (lfsr_fire) lfsr_sent <= 1'b1;
            if (misr_fire) misr_sent <= 1'b1;
          end
        end
        WAIT_SIG: begin
          if (resp_fire) begin
            result[idx] <= sig_match;
            if (idx != LAST_IDX) idx <= idx + IDX_BITS'(1);
          end
        end
        DONE: begin
          if (done_fire) idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lbist_controller.sv
// Bench for lbist_controller: table-driven runs, randomized runs against a transaction model,
// and hand-written reset / stray-response sequences.
module tb_lbist_controller;

  localparam int unsigned NS = 2;
  localparam logic [31:0] SEED_TAB [NS] = '{32'h0000_1234, 32'h0000_BEEF};
  localparam logic [31:0] GOLD_TAB [NS] = '{32'h0000_5A5A, 32'h0000_A5A5};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_val = 1'b0;
  logic        start_rdy;
  logic        lfsr_req_val;
  logic [31:0] lfsr_req_msg;
  logic        lfsr_req_rdy = 1'b0;
  logic        misr_req_val;
  logic [5:0]  misr_req_msg;
  logic        misr_req_rdy = 1'b0;
  logic        misr_resp_val = 1'b0;
  logic [31:0] misr_resp_msg = '0;
  logic        misr_resp_rdy;
  logic        done_val;
  logic [1:0]  done_msg;
  logic        done_rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  lbist_controller #(
    .SEED_BITS(32), .SIGNATURE_BITS(32), .NUM_SEEDS(NS), .MAX_OUTPUTS_TO_HASH(32),
    .SEEDS({32'hBEEF, 32'h1234}), .SIGNATURES({32'hA5A5, 32'h5A5A})
  ) dut (
    .clk(clk), .reset(reset),
    .start_val(start_val), .start_rdy(start_rdy),
    .lfsr_req_val(lfsr_req_val), .lfsr_req_msg(lfsr_req_msg), .lfsr_req_rdy(lfsr_req_rdy),
    .misr_req_val(misr_req_val), .misr_req_msg(misr_req_msg), .misr_req_rdy(misr_req_rdy),
    .misr_resp_val(misr_resp_val), .misr_resp_msg(misr_resp_msg), .misr_resp_rdy(misr_resp_rdy),
    .done_val(done_val), .done_msg(done_msg), .done_rdy(done_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lw;
    int          mw;
    int          rw;
    int          dw;
    logic [31:0] s0;
    logic [31:0] s1;
    bit          hold;
    bit          stray;
    logic [1:0]  exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " start_rdy"}, 32'(start_rdy), 1);
    chk({tag, " lfsr_val"}, 32'(lfsr_req_val), 0);
    chk({tag, " misr_val"}, 32'(misr_req_val), 0);
    chk({tag, " resp_rdy"}, 32'(misr_resp_rdy), 0);
    chk({tag, " done_val"}, 32'(done_val), 0);
    chk({tag, " done_msg"}, 32'(done_msg), 0);
  endtask

  // One full run. Peers stall lw/mw cycles before accepting, the signature arrives rw cycles
  // into WAIT_SIG, and the host stalls dw cycles on the result.
  task automatic do_run(input int lw, input int mw, input int rw, input int dw,
                        input logic [31:0] s0, input logic [31:0] s1,
                        input bit hold, input bit stray, input logic [1:0] exp_done);
    int cyc;
    logic [31:0] sig;
    @(negedge clk);
    chk("run start_rdy", 32'(start_rdy), 1);
    chk("run idle lfsr_val", 32'(lfsr_req_val), 0);
    start_val = 1'b1;
    @(negedge clk);
    start_val = 1'b0;
    cyc = 1;
    for (int s = 0; s < int'(NS); s++) begin
      int lc = lw;
      int mc = mw;
      bit lf = 1'b0;
      bit mf = 1'b0;
      while (!(lf && mf)) begin
        chk("send lfsr_val", 32'(lfsr_req_val), 32'(!lf));
        if (!lf) chk("send lfsr_msg", lfsr_req_msg, SEED_TAB[s]);
        chk("send misr_val", 32'(misr_req_val), 32'(!mf));
        chk("send misr_msg", 32'(misr_req_msg), 32);
        chk("send resp_rdy", 32'(misr_resp_rdy), 0);
        chk("send start_rdy", 32'(start_rdy), 0);
        lfsr_req_rdy  = (lc == 0);
        misr_req_rdy  = (mc == 0);
        misr_resp_val = stray && ($urandom_range(0, 1) == 1);
        misr_resp_msg = ~GOLD_TAB[s];
        if (lc == 0) lf = 1'b1; else lc--;
        if (mc == 0) mf = 1'b1; else mc--;
        @(negedge clk);
        cyc++;
      end
      lfsr_req_rdy = 1'b0;
      misr_req_rdy = 1'b0;
      sig = (s == 0) ? s0 : s1;
      for (int r = 0; r <= rw; r++) begin
        chk("wait resp_rdy", 32'(misr_resp_rdy), 1);
        chk("wait lfsr_val", 32'(lfsr_req_val), 0);
        chk("wait misr_val", 32'(misr_req_val), 0);
        chk("wait done_val", 32'(done_val), 0);
        misr_resp_val = (r == rw);
        misr_resp_msg = (r == rw) ? sig : $urandom;
        @(negedge clk);
        cyc++;
      end
      misr_resp_val = 1'b0;
    end
    if (lw == 0 && mw == 0 && rw == 0) chk("min latency", 32'(cyc), 32'(2 * NS + 1));
    for (int d = 0; d <= dw; d++) begin
      chk("done val", 32'(done_val), 1);
      chk("done msg", 32'(done_msg), 32'(exp_done));
      chk("done start_rdy", 32'(start_rdy), 0);
      chk("done resp_rdy", 32'(misr_resp_rdy), 0);
      done_rdy  = (d == dw);
      start_val = hold && (d < dw);
      @(negedge clk);
    end
    done_rdy  = 1'b0;
    start_val = 1'b0;
    chk("post start_rdy", 32'(start_rdy), 1);
    chk("post done_val", 32'(done_val), 0);
  endtask

  initial begin
    vec_t tab [8];
    tab[0] = '{0, 0, 0, 0, 32'h5A5A, 32'hA5A5, 1'b0, 1'b0, 2'b11};
    tab[1] = '{0, 0, 0, 0, 32'h5A5A, 32'h0000, 1'b0, 1'b0, 2'b01};
    tab[2] = '{0, 0, 0, 0, 32'h5A5A, 32'hA5A5, 1'b0, 1'b0, 2'b11};
    tab[3] = '{3, 0, 0, 0, 32'h5A5A, 32'hA5A5, 1'b0, 1'b0, 2'b11};
    tab[4] = '{0, 0, 0, 4, 32'h5A5A, 32'hA5A5, 1'b1, 1'b0, 2'b11};
    tab[5] = '{0, 2, 1, 0, 32'h0000, 32'hA5A5, 1'b0, 1'b0, 2'b10};
    tab[6] = '{1, 1, 2, 1, 32'h5A5A, 32'hA5A5, 1'b0, 1'b1, 2'b11};
    tab[7] = '{2, 2, 0, 0, 32'hFFFF_5A5A, 32'hA5A5, 1'b0, 1'b0, 2'b10};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_idle("reset");
    chk("reset lfsr_msg", lfsr_req_msg, 32'h1234);
    chk("reset misr_msg", 32'(misr_req_msg), 32);

    foreach (tab[i])
      do_run(tab[i].lw, tab[i].mw, tab[i].rw, tab[i].dw, tab[i].s0, tab[i].s1,
             tab[i].hold, tab[i].stray, tab[i].exp_done);

    // Stray signature while idle is not accepted and does not disturb the next run
    @(negedge clk);
    misr_resp_val = 1'b1;
    misr_resp_msg = 32'h5A5A;
    chk("stray idle resp_rdy", 32'(misr_resp_rdy), 0);
    @(negedge clk);
    misr_resp_val = 1'b0;
    chk_idle("stray idle");
    do_run(0, 0, 0, 0, 32'h0, 32'hA5A5, 1'b0, 1'b1, 2'b10);

    // Reset in WAIT_SIG of seed 1
    lfsr_req_rdy = 1'b1;
    misr_req_rdy = 1'b1;
    @(negedge clk);
    start_val = 1'b1;
    @(negedge clk);
    start_val = 1'b0;
    @(negedge clk);
    misr_resp_val = 1'b1;
    misr_resp_msg = 32'h5A5A;
    @(negedge clk);
    misr_resp_val = 1'b0;
    chk("rst seed1 lfsr_msg", lfsr_req_msg, 32'hBEEF);
    @(negedge clk);
    lfsr_req_rdy = 1'b0;
    misr_req_rdy = 1'b0;
    chk("rst pre resp_rdy", 32'(misr_resp_rdy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("midrun reset");
    chk("midrun reset lfsr_msg", lfsr_req_msg, 32'h1234);
    do_run(0, 0, 0, 0, 32'h5A5A, 32'hA5A5, 1'b0, 1'b0, 2'b11);

    // Randomized runs; expected result bits come from golden-table equality
    for (int n = 0; n < 20; n++) begin
      logic [31:0] s0, s1;
      logic [1:0]  exp_done;
      s0 = ($urandom_range(0, 1) == 1) ? GOLD_TAB[0] : GOLD_TAB[0] ^ (32'h1 << $urandom_range(0, 31));
      s1 = ($urandom_range(0, 1) == 1) ? GOLD_TAB[1] : $urandom;
      exp_done = {s1 == GOLD_TAB[1], s0 == GOLD_TAB[0]};
      do_run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), s0, s1, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), exp_done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
